// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier, one add/sub + shift per clock.
// Define BOOTH_SEQ_ABORT_EN to add an abort input that cancels a RUN.
module booth_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef BOOTH_SEQ_ABORT_EN
  input  logic               abort,
`endif
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH:0]     r_a;
  logic [WIDTH:0]     r_m;
  logic [WIDTH-1:0]   r_q;
  logic               r_qm1;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_product;

  logic               w_abort;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH+1:0] w_sh;

`ifdef BOOTH_SEQ_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CW'(1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_sum = r_a;
    case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_a + r_m;
      2'b10:   w_sum = r_a - r_m;
      default: w_sum = r_a;
    endcase
    // {A',Q,q_m1} >>> 1: q_m1 drops out, sign of A' enters on the left
    w_sh = {w_sum[WIDTH], w_sum, r_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_m       <= '0;
      r_q       <= '0;
      r_qm1     <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      if (w_accept) begin
        r_a   <= '0;
        r_q   <= multiplier;
        r_qm1 <= 1'b0;
        r_m   <= {multiplicand[WIDTH-1], multiplicand};
        r_cnt <= CW'(WIDTH);
      end else if (r_state == S_RUN) begin
        r_a   <= w_sh[2*WIDTH+1:WIDTH+1];
        r_q   <= w_sh[WIDTH:1];
        r_qm1 <= w_sh[0];
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_last) r_product <= w_sh[2*WIDTH:1];
    end
  end

  assign ready   = (r_state == S_IDLE);
  assign busy    = (r_state == S_RUN) || (r_state == S_DONE);
  assign done    = (r_state == S_DONE);
  assign product = r_product;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Bench for booth_seq_ctrl: directed corner cases plus random operands
// checked against a plain signed-multiply reference.
module tb_booth_seq_ctrl;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
`ifdef BOOTH_SEQ_ABORT_EN
  logic           abort;
`endif
  logic [W-1:0]   mc;
  logic [W-1:0]   mp;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  booth_seq_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
`ifdef BOOTH_SEQ_ABORT_EN
    .abort       (abort),
`endif
    .multiplicand(mc),
    .multiplier  (mp),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m,
                                             input logic [W-1:0] q);
    longint a;
    longint b;
    longint p;
    a = longint'($signed(m));
    b = longint'($signed(q));
    p = a * b;
    return p[2*W-1:0];
  endfunction

  task automatic wait_ready;
    int k = 0;
    while (!ready && k < 50) begin
      tick;
      k++;
    end
    chk("ready_wait", 64'(ready), 64'd1);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      tick;
      lat++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q);
    int lat;
    wait_ready;
    mc    = m;
    mp    = q;
    start = 1'b1;
    tick;
    start = 1'b0;
    mc    = W'($urandom);
    mp    = W'($urandom);
    chk("busy_run", 64'(busy), 64'd1);
    wait_done(lat);
    chk("latency", 64'(lat), 64'(W));
    chk("product", 64'(product), 64'(ref_mul(m, q)));
    tick;
    chk("done_pulse", 64'(done), 64'd0);
    chk("ready_after", 64'(ready), 64'd1);
  endtask

  initial begin
    int lat;
    int nd;
    int t0;
    int t1;
    int t2;
    bit rdy_seen;
    logic [W-1:0]   rm;
    logic [W-1:0]   rq;
    logic [2*W-1:0] hold;

    rst_n = 1'b0;
    start = 1'b1;
    mc    = W'(3);
    mp    = W'(3);
`ifdef BOOTH_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    tick;
    tick;
    start = 1'b0;
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_product", 64'(product), 64'd0);
    rst_n = 1'b1;
    tick;

    run_op(W'(3), W'(-4));
    run_op(W'(-128), W'(-128));
    chk("min_min", 64'(product), 64'h4000);
    run_op(W'(127), W'(-128));
    chk("max_min", 64'(product), 64'hC080);
    run_op(W'(0), W'(-1));

    // second start during RUN must be ignored
    wait_ready;
    mc = W'(5); mp = W'(7); start = 1'b1;
    tick;
    start = 1'b0;
    rdy_seen = ready;
    tick; rdy_seen |= ready;
    tick; rdy_seen |= ready;
    mc = W'(9); mp = W'(9); start = 1'b1;
    tick;
    start = 1'b0;
    rdy_seen |= ready;
    lat = 0;
    while (!done && lat < 40) begin
      rdy_seen |= ready;
      tick;
      lat++;
    end
    chk("ign_ready_low", 64'(rdy_seen), 64'd0);
    chk("ign_product", 64'(product), 64'd35);
    nd = 0;
    for (int i = 0; i < W + 4; i++) begin
      tick;
      if (done) nd++;
    end
    chk("ign_no_second", 64'(nd), 64'd0);

    // reset in the middle of an operation
    wait_ready;
    mc = W'(10); mp = W'(10); start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_product", 64'(product), 64'd0);
    nd = 0;
    for (int i = 0; i < W + 4; i++) begin
      tick;
      if (done) nd++;
    end
    chk("mid_rst_no_done", 64'(nd), 64'd0);
    run_op(W'(2), W'(3));

    // start held high: one result every W+2 cycles
    wait_ready;
    mc = W'(-7); mp = W'(6); start = 1'b1;
    nd = 0; t0 = 0; t1 = 0; t2 = 0;
    for (int i = 1; i <= 30; i++) begin
      tick;
      if (done) begin
        chk("held_product", 64'(product), 64'hFFD6);
        if (nd == 0) t0 = i;
        if (nd == 1) t1 = i;
        if (nd == 2) t2 = i;
        nd++;
      end
    end
    start = 1'b0;
    chk("held_count", 64'(nd), 64'd3);
    chk("held_gap1", 64'(t1 - t0), 64'(W + 2));
    chk("held_gap2", 64'(t2 - t1), 64'(W + 2));

    for (int n = 0; n < 40; n++) begin
      rm = W'($urandom);
      rq = W'($urandom);
      run_op(rm, rq);
      hold = ref_mul(rm, rq);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick;
      chk("rand_hold", 64'(product), 64'(hold));
    end

`ifdef BOOTH_SEQ_ABORT_EN
    run_op(W'(4), W'(4));
    wait_ready;
    mc = W'(3); mp = W'(3); start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_product", 64'(product), 64'd16);
    nd = 0;
    for (int i = 0; i < W + 4; i++) begin
      tick;
      if (done) nd++;
    end
    chk("abort_no_done", 64'(nd), 64'd0);
    mc = W'(2); mp = W'(6); start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    chk("abort_idle_accept", 64'(busy), 64'd1);
    wait_done(lat);
    chk("abort_idle_lat", 64'(lat), 64'(W));
    chk("abort_idle_product", 64'(product), 64'd12);
    tick;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/booth_seq_ctrl.md
Name: booth_seq_ctrl

Overview:
- Sequential radix-2 Booth multiplier: an FSM-driven controller around an accumulator/shift datapath.
- Sequences one add/subtract-then-arithmetic-shift iteration per clock over WIDTH cycles.
- Replaces the unrolled combinational loop wherever multiply area matters, e.g. convolution MAC lanes.
- Uses a start/ready/done handshake so an upstream scheduler can issue operands and collect signed products.

Parameters:
WIDTH, 8, operand width in bits (signed two's complement); product is 2*WIDTH bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request; accepted only when ready=1
multiplicand  input  WIDTH  signed operand M, sampled on accept
multiplier  input  WIDTH  signed operand Q, sampled on accept
ready  output  1  high in IDLE only
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; product valid
product  output  2*WIDTH  signed result, held until next completion

Behaviour:
- One clock domain; reset is synchronous and active-low: rst_n low at a rising clk edge forces the reset state, no asynchronous path.
- Reset values: state=IDLE, ready=1, busy=0, done=0, product=0. All internal registers (A, Q, q_m1, M, cnt) are cleared.
- Internal registers:
  - A: WIDTH+1 bits signed. The extra bit absorbs the overflow of A-M when M = -2^(WIDTH-1).
  - Q: WIDTH bits.
  - q_m1: 1 bit.
  - M: WIDTH+1 bits, sign-extended.
  - cnt: ceil(log2(WIDTH+1)) bits.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: A=0, Q=multiplier, q_m1=0, M=sext(multiplicand), cnt=WIDTH; go to RUN.
  - start=0: stay in IDLE.
- RUN, each edge, with pair={Q[0],q_m1}:
  - 01: A'=A+M.
  - 10: A'=A-M.
  - 00 or 11: A'=A.
  - Then arithmetic right shift of {A',Q,q_m1} by 1; the sign bit A'[WIDTH] is replicated.
  - cnt decrements.
  - When cnt==1 at the edge, this is the last iteration: load product={A_next[WIDTH-1:0],Q_next} and go to DONE.
- DONE: done=1 for exactly this cycle; next edge returns to IDLE.
- Latency: if start is accepted at edge k, done is high in the cycle after edge k+WIDTH. Issue-to-issue throughput is WIDTH+2 cycles.
- start while busy=1 is ignored. No queuing; operand inputs are don't-care.
- start held high continuously: a new operation is accepted at the first edge after returning to IDLE.
- product changes only at the RUN->DONE edge and at reset; it holds between operations.
- Arithmetic is exact for all operand pairs, including -2^(WIDTH-1) * -2^(WIDTH-1) = +2^(2*WIDTH-2), which fits in 2*WIDTH signed bits.
- Reset mid-operation (rst_n low in RUN or DONE): immediate return to the reset state; no done pulse; product=0.
- rst_n low and start high on the same edge: reset wins.

Optional Feature:
- Macro: BOOTH_SEQ_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit), placed after start.
  - abort=1 at an edge in RUN: go to IDLE next cycle, no done pulse, product keeps its previous value.
  - abort in IDLE or DONE has no effect.
  - abort and start on the same edge in IDLE: start is accepted.
- When undefined: the port does not exist and RUN always completes.

Test Plan:
- Reset, then WIDTH=8: M=3, Q=-4, start pulse -> done after 8 cycles; product=16'hFFF4 (-12); ready high again the next cycle.
- M=-128, Q=-128 -> product=16'h4000 (16384). Also M=127, Q=-128 -> product=16'hC080 (-16256). Also M=0, Q=-1 -> product=0.
- Issue M=5, Q=7, then pulse start with M=9, Q=9 during RUN -> single done with product=35. The second request is ignored; ready=0 throughout the operation.
- Assert rst_n=0 for one edge at iteration 4 of M=10, Q=10 -> busy=0, done never pulses, product=0. A following M=2, Q=3 run gives product=6.
- start held high for 30 cycles with fixed M=-7, Q=6 -> done pulses every 10 cycles, each with product=16'hFFD6 (-42).
- With BOOTH_SEQ_ABORT_EN:
  - Complete M=4, Q=4 (product=16).
  - Start M=3, Q=3 and abort in RUN -> no done, product stays 16, ready=1 the next cycle.
